keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Sequencer for the 4x4 PMOD keypad: drives one column low at a time, samples the rows, debounces and emits one decoded 4-bit key code with a single-cycle strobe per press.
- Sits between the keypad pins and the binary-to-BCD / seven-segment display path, and replaces free-running column scanning with a controlled scan, lock, and release-wait cycle.

Parameters:
- SCAN_DIV, 50000: clock_in cycles per column slot; must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive equal row samples needed to accept a press or a release; must be >= 1.
- REPEAT_TICKS, 20: hold ticks before and between auto-repeat strobes; used only with the optional feature.

Ports:
- clock_in  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous
- col_drive  output  4  keypad columns, active-low, exactly one bit low at all times
- scan_col  output  2  index of the column currently driven low
- key_code  output  4  last accepted key value
- key_valid  output  1  one-cycle strobe when key_code updates
- key_held  output  1  high while an accepted key is still pressed

Behaviour:
- Reset (async, active-high): col_drive=4'b1110, scan_col=0, key_code=0, key_valid=0, key_held=0, state=SCAN, divider=0, debounce count=0, row synchroniser=4'b1111.
- row_in passes through a 2-flop synchroniser (rs) before any use.
- Divider counts 0..SCAN_DIV-1 and wraps. tick is high when the divider equals SCAN_DIV-1. All FSM decisions happen only on tick cycles.
- col_drive = ~(4'b0001 << scan_col). scan_col advances (mod 4, wrapping 3->0) only where stated below.
- Row priority: if more than one rs bit is low, the lowest row index wins.
- SCAN:
  - On tick, if rs == 4'b1111: advance scan_col.
  - On tick, otherwise: latch (col=scan_col, row=winning index), set count=1, go DEBOUNCE. If DEBOUNCE_SCANS==1, treat as accepted immediately (see DEBOUNCE).
- DEBOUNCE:
  - scan_col is held.
  - On tick with the same winning row low: count+1.
  - When count reaches DEBOUNCE_SCANS: key_code=map(col,row) and key_valid=1 for exactly one cycle (the cycle after that tick), key_held=1, go HELD with count=0.
  - On tick with a different row or no row low: go SCAN and advance scan_col. No strobe.
- HELD:
  - scan_col is held.
  - On tick with the latched row high: count+1. On tick with it low: count=0.
  - When count reaches DEBOUNCE_SCANS: key_held=0, go SCAN and advance scan_col.
  - A second key pressed in another column is ignored until release completes.
- Key map, key_code[3:0] indexed [col][row0..row3]:
  - col0: 1,4,7,0
  - col1: 2,5,8,F
  - col2: 3,6,9,E
  - col3: A,B,C,D
- Latency:
  - Press held steady on the driven column → key_valid = DEBOUNCE_SCANS ticks after first detection, +1 cycle.
  - Worst case from press start ≈ (3+DEBOUNCE_SCANS)·SCAN_DIV + 3 cycles (2 synchroniser + 1 strobe).
- key_code holds its value until the next accepted press. key_valid is never high on two consecutive cycles.
- Reset asserted mid-press: everything returns to reset values. If the key is still down after reset release, it is detected afresh and strobed once.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in HELD, a separate hold-tick counter counts ticks while the key stays low.
  - After REPEAT_TICKS ticks, key_valid pulses again with the same key_code, and repeats every REPEAT_TICKS ticks after that.
  - The counter clears on entry to HELD and on any tick where the key reads released.
- Not defined: exactly one strobe per press; the hold counter and REPEAT_TICKS are not synthesised.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_TICKS=5):
- Reset then idle rows 4'b1111 → col_drive cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clocks; key_valid stays 0.
- Hold row1 low whenever col2 is driven, stable → exactly one key_valid pulse with key_code=6; key_held=1; col_drive frozen at 1011 until release.
- Release row1, hold high for 3 ticks → key_held falls, scanning resumes from col3 (0111); no further strobes.
- Bounce: row0 low on col0 for 2 ticks, then high → no strobe, FSM back in SCAN, scan_col=1.
- Rows 0 and 3 both low on col1 → key_code=2 (lowest row wins). Assert reset mid-HELD → outputs return to reset values; key still down after reset release → one new strobe.
- With KEYPAD_REPEAT_EN: hold key D (col3,row3) for 20 ticks → initial strobe, then strobes every 5 ticks with key_code=D. Without the macro: one strobe only.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scan sequencer for a 4x4 active-low keypad. It drives one column low at
//   a time and samples the synchronised rows once per column slot. A press
//   must be seen on the same row for DEBOUNCE_SCANS slots before it is
//   accepted. The accepted key is then locked until the same number of
//   released slots has been seen.
//
//   Optional build macro: KEYPAD_REPEAT_EN
//     When defined, a held key re-strobes key_valid every REPEAT_TICKS slots.
//
// Ports
//   clock_in   in   system clock
//   reset      in   asynchronous, active-high reset
//   row_in     in   [3:0] keypad rows, active-low, asynchronous to clock_in
//   col_drive  out  [3:0] keypad columns, exactly one bit low
//   scan_col   out  [1:0] index of the column currently driven low
//   key_code   out  [3:0] last accepted key value
//   key_valid  out  one-cycle strobe when key_code is (re)issued
//   key_held   out  high while the accepted key is still down
//
// States
//   SCAN     | rotating columns, waiting for any row low
//   DEBOUNCE | column frozen, counting stable samples of the detected row
//   HELD     | key accepted, counting released samples before rescanning
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_TICKS   = 20
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic [1:0] scan_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4)       begin : g_bad_div  $error("SCAN_DIV must be >= 4");       end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_deb  $error("DEBOUNCE_SCANS must be >= 1"); end
    if (REPEAT_TICKS < 1)   begin : g_bad_rep  $error("REPEAT_TICKS must be >= 1");   end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t           state, state_nx;
    logic [3:0]       rs_meta, rs;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [CNT_W-1:0] count, count_nx, count_inc;
    logic [1:0]       scan_col_nx, lat_col, lat_col_nx, lat_row, lat_row_nx, win_row;
    logic             any_low;
    logic [3:0]       key_code_nx;
    logic             key_valid_nx, key_held_nx;

`ifdef KEYPAD_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(REPEAT_TICKS);
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx, hold_inc;
    assign hold_inc = hold_cnt + 1'b1;
`endif

    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        case ({c, r})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h4;  4'h2: key_map = 4'h7;  4'h3: key_map = 4'h0;
            4'h4: key_map = 4'h2;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h8;  4'h7: key_map = 4'hF;
            4'h8: key_map = 4'h3;  4'h9: key_map = 4'h6;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hE;
            4'hC: key_map = 4'hA;  4'hD: key_map = 4'hB;  4'hE: key_map = 4'hC;  default: key_map = 4'hD;
        endcase
    endfunction

    assign tick      = (div == DIV_LAST);
    assign any_low   = (rs != 4'b1111);
    assign count_inc = count + 1'b1;
    assign col_drive = ~(4'b0001 << scan_col);

    // Lowest-numbered low row wins when several rows are pulled down.
    always_comb begin
        if      (!rs[0]) win_row = 2'd0;
        else if (!rs[1]) win_row = 2'd1;
        else if (!rs[2]) win_row = 2'd2;
        else             win_row = 2'd3;
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            rs_meta   <= 4'b1111;
            rs        <= 4'b1111;
            div       <= '0;
            state     <= SCAN;
            scan_col  <= 2'd0;
            count     <= '0;
            lat_col   <= 2'd0;
            lat_row   <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            rs_meta   <= row_in;
            rs        <= rs_meta;
            div       <= tick ? '0 : div + 1'b1;
            state     <= state_nx;
            scan_col  <= scan_col_nx;
            count     <= count_nx;
            lat_col   <= lat_col_nx;
            lat_row   <= lat_row_nx;
            key_code  <= key_code_nx;
            key_valid <= key_valid_nx;
            key_held  <= key_held_nx;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) hold_cnt <= '0;
        else       hold_cnt <= hold_cnt_nx;
    end
`endif

    always_comb begin
        state_nx     = state;
        scan_col_nx  = scan_col;
        count_nx     = count;
        lat_col_nx   = lat_col;
        lat_row_nx   = lat_row;
        key_code_nx  = key_code;
        key_valid_nx = 1'b0;
        key_held_nx  = key_held;
`ifdef KEYPAD_REPEAT_EN
        hold_cnt_nx  = hold_cnt;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (!any_low) begin
                        scan_col_nx = scan_col + 2'd1;
                    end else begin
                        lat_col_nx = scan_col;
                        lat_row_nx = win_row;
                        // A single required sample means the detection itself is the acceptance.
                        if (CNT_DONE == CNT_W'(1)) begin
                            key_code_nx  = key_map(scan_col, win_row);
                            key_valid_nx = 1'b1;
                            key_held_nx  = 1'b1;
                            count_nx     = '0;
                            state_nx     = HELD;
`ifdef KEYPAD_REPEAT_EN
                            hold_cnt_nx  = '0;
`endif
                        end else begin
                            count_nx = CNT_W'(1);
                            state_nx = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (any_low && (win_row == lat_row)) begin
                        if (count_inc == CNT_DONE) begin
                            key_code_nx  = key_map(lat_col, lat_row);
                            key_valid_nx = 1'b1;
                            key_held_nx  = 1'b1;
                            count_nx     = '0;
                            state_nx     = HELD;
`ifdef KEYPAD_REPEAT_EN
                            hold_cnt_nx  = '0;
`endif
                        end else begin
                            count_nx = count_inc;
                        end
                    end else begin
                        count_nx    = '0;
                        state_nx    = SCAN;
                        scan_col_nx = scan_col + 2'd1;
                    end
                end
                HELD: begin
                    // Only the latched row matters; other keys are ignored until release.
                    if (rs[lat_row]) begin
`ifdef KEYPAD_REPEAT_EN
                        hold_cnt_nx = '0;
`endif
                        if (count_inc == CNT_DONE) begin
                            count_nx    = '0;
                            key_held_nx = 1'b0;
                            state_nx    = SCAN;
                            scan_col_nx = scan_col + 2'd1;
                        end else begin
                            count_nx = count_inc;
                        end
                    end else begin
                        count_nx = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (hold_inc == HOLD_DONE) begin
                            key_valid_nx = 1'b1;
                            hold_cnt_nx  = '0;
                        end else begin
                            hold_cnt_nx = hold_inc;
                        end
`endif
                    end
                end
                default: state_nx = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;
    localparam int SD = 4;
    localparam int DS = 3;
    localparam int RT = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [1:0] scan_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_TICKS(RT)) dut (
        .clock_in (clk),
        .reset    (reset),
        .row_in   (row_in),
        .col_drive(col_drive),
        .scan_col (scan_col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low only while its column is driven low.
    logic key_down [0:3][0:3];
    always_comb begin
        row_in = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (key_down[c][r] && (col_drive[c] == 1'b0)) row_in[r] = 1'b0;
    end

    logic [3:0] keymap [16] = '{4'h1, 4'h4, 4'h7, 4'h0,
                                4'h2, 4'h5, 4'h8, 4'hF,
                                4'h3, 4'h6, 4'h9, 4'hE,
                                4'hA, 4'hB, 4'hC, 4'hD};

    int checks = 0;
    int failures = 0;

    int         strobe_cnt = 0;
    logic [3:0] last_code = 4'h0;
    logic       last_held = 1'b0;
    logic       prev_valid = 1'b0;
    logic       consec_seen = 1'b0;
    logic       col_bad = 1'b0;

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            last_code  = key_code;
            last_held  = key_held;
        end
        if (prev_valid && (key_valid === 1'b1)) consec_seen = 1'b1;
        prev_valid = (key_valid === 1'b1);
        if (!(col_drive inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) col_bad = 1'b1;
    end

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] p;
        p = 4'b0001 << c;
        return ~p;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++; if (col_drive !== 4'b1110) begin failures++; $display("FAIL %s col_drive got=%b exp=1110", tag, col_drive); end
        checks++; if (scan_col !== 2'd0)     begin failures++; $display("FAIL %s scan_col got=%0d exp=0", tag, scan_col); end
        checks++; if (key_code !== 4'h0)     begin failures++; $display("FAIL %s key_code got=%h exp=0", tag, key_code); end
        checks++; if (key_valid !== 1'b0)    begin failures++; $display("FAIL %s key_valid got=%b exp=0", tag, key_valid); end
        checks++; if (key_held !== 1'b0)     begin failures++; $display("FAIL %s key_held got=%b exp=0", tag, key_held); end
    endtask

    task automatic test_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check_reset_values("reset");
    endtask

    task automatic test_idle_scan();
        int start;
        start = strobe_cnt;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (scan_col !== 2'((k / SD) % 4)) begin
                failures++; $display("FAIL idle_scan_col k=%0d got=%0d exp=%0d", k, scan_col, (k / SD) % 4);
            end
            checks++;
            if (col_drive !== col_pat((k / SD) % 4)) begin
                failures++; $display("FAIL idle_col_drive k=%0d got=%b exp=%b", k, col_drive, col_pat((k / SD) % 4));
            end
        end
        checks++;
        if (strobe_cnt != start) begin failures++; $display("FAIL idle_strobes got=%0d exp=0", strobe_cnt - start); end
    endtask

    task automatic press(input int c, input logic [3:0] mask, input logic [3:0] exp, input string tag);
        int start;
        start = strobe_cnt;
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) if (mask[r]) key_down[c][r] = 1'b1;
        for (int i = 0; i < 60 && strobe_cnt == start; i++) begin @(posedge clk); #1; end
        checks++;
        if (strobe_cnt == start) begin
            failures++; $display("FAIL %s strobe_timeout got=none exp=strobe within 60 cycles", tag);
        end else begin
            checks++; if (last_code !== exp) begin failures++; $display("FAIL %s key_code got=%h exp=%h", tag, last_code, exp); end
            checks++; if (last_held !== 1'b1) begin failures++; $display("FAIL %s held_at_strobe got=%b exp=1", tag, last_held); end
        end
        repeat (3 * SD) @(posedge clk);
        #1;
        checks++; if (col_drive !== col_pat(c)) begin failures++; $display("FAIL %s frozen_col got=%b exp=%b", tag, col_drive, col_pat(c)); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL %s key_held got=%b exp=1", tag, key_held); end
        checks++; if (key_code !== exp) begin failures++; $display("FAIL %s code_hold got=%h exp=%h", tag, key_code, exp); end
`ifndef KEYPAD_REPEAT_EN
        checks++; if (strobe_cnt != start + 1) begin failures++; $display("FAIL %s strobe_count got=%0d exp=1", tag, strobe_cnt - start); end
`endif
    endtask

    task automatic release_col(input int c, input string tag);
        int start;
        start = strobe_cnt;
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) key_down[c][r] = 1'b0;
        for (int i = 0; i < 40 && key_held === 1'b1; i++) begin @(posedge clk); #1; end
        checks++;
        if (key_held !== 1'b0) begin
            failures++; $display("FAIL %s release_timeout key_held got=%b exp=0", tag, key_held);
        end else begin
            checks++;
            if (col_drive !== col_pat((c + 1) % 4)) begin
                failures++; $display("FAIL %s resume_col got=%b exp=%b", tag, col_drive, col_pat((c + 1) % 4));
            end
        end
        repeat (8 * SD) @(posedge clk);
        #1;
        checks++; if (strobe_cnt != start) begin failures++; $display("FAIL %s release_strobes got=%0d exp=0", tag, strobe_cnt - start); end
    endtask

    task automatic test_key6();
        do_reset();
        press(2, 4'b0010, 4'h6, "key6");
        release_col(2, "key6_rel");
    endtask

    task automatic test_bounce();
        int start;
        key_down[0][0] = 1'b1;
        do_reset();
        start = strobe_cnt;
        repeat (2 * SD) @(posedge clk);
        #1;
        checks++; if (scan_col !== 2'd0) begin failures++; $display("FAIL bounce_hold_col got=%0d exp=0", scan_col); end
        key_down[0][0] = 1'b0;
        repeat (SD) @(posedge clk);
        #1;
        checks++; if (scan_col !== 2'd1) begin failures++; $display("FAIL bounce_scan_col got=%0d exp=1", scan_col); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL bounce_held got=%b exp=0", key_held); end
        repeat (4 * SD) @(posedge clk);
        #1;
        checks++; if (strobe_cnt != start) begin failures++; $display("FAIL bounce_strobes got=%0d exp=0", strobe_cnt - start); end
    endtask

    task automatic test_multi_row();
        press(1, 4'b1001, 4'h2, "multi_row");
        release_col(1, "multi_row_rel");
    endtask

    task automatic test_reset_mid_held();
        int start;
        press(2, 4'b0100, 4'h9, "mid_held");
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check_reset_values("mid_held_reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        start = strobe_cnt;
        for (int i = 0; i < 60 && strobe_cnt == start; i++) begin @(posedge clk); #1; end
        checks++;
        if (strobe_cnt == start) begin
            failures++; $display("FAIL mid_held_restrobe_timeout got=none exp=strobe");
        end else begin
            checks++; if (last_code !== 4'h9) begin failures++; $display("FAIL mid_held_recode got=%h exp=9", last_code); end
        end
        repeat (3 * SD) @(posedge clk);
        #1;
        checks++; if (strobe_cnt != start + 1) begin failures++; $display("FAIL mid_held_restrobe_count got=%0d exp=1", strobe_cnt - start); end
        release_col(2, "mid_held_rel");
    endtask

    task automatic test_random();
        int c, r;
        logic [3:0] mask;
        for (int n = 0; n < 6; n++) begin
            c = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 3));
            mask = 4'(1 << r);
            press(c, mask, keymap[c * 4 + r], $sformatf("rand%0d_c%0d_r%0d", n, c, r));
            release_col(c, $sformatf("rand%0d_rel", n));
        end
    endtask

    task automatic test_repeat();
        int start, exp_rep;
        localparam int HOLD = 84;
        start = strobe_cnt;
        @(posedge clk); #1 key_down[3][3] = 1'b1;
        for (int i = 0; i < 60 && strobe_cnt == start; i++) begin @(posedge clk); #1; end
        checks++;
        if (strobe_cnt == start) begin
            failures++; $display("FAIL repeat_first_timeout got=none exp=strobe");
        end else begin
            checks++; if (last_code !== 4'hD) begin failures++; $display("FAIL repeat_first_code got=%h exp=d", last_code); end
            start = strobe_cnt;
            repeat (HOLD) @(posedge clk);
            #1;
`ifdef KEYPAD_REPEAT_EN
            exp_rep = (HOLD + 1) / (RT * SD);
`else
            exp_rep = 0;
`endif
            checks++;
            if (strobe_cnt - start != exp_rep) begin
                failures++; $display("FAIL repeat_count got=%0d exp=%0d", strobe_cnt - start, exp_rep);
            end
            checks++; if (last_code !== 4'hD) begin failures++; $display("FAIL repeat_code got=%h exp=d", last_code); end
        end
        release_col(3, "repeat_rel");
    endtask

    task automatic test_invariants();
        checks++; if (consec_seen !== 1'b0) begin failures++; $display("FAIL consecutive_valid got=%b exp=0", consec_seen); end
        checks++; if (col_bad !== 1'b0) begin failures++; $display("FAIL col_onehot got=%b exp=0", col_bad); end
    endtask

    initial begin
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                key_down[c][r] = 1'b0;
        test_reset();
        test_idle_scan();
        test_key6();
        test_bounce();
        test_multi_row();
        test_reset_mid_held();
        test_random();
        test_repeat();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
